// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one strobe-style memory/IO slave between two masters (m0 = CPU, m1 = loader/DMA).
// A granted request is registered, issued to the slave as a single one-cycle strobe, the slave
// read latency is waited out, then read data and a one-cycle done pulse go back to the owner.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_mN_addr/wdata/wstrb   master N request address, write data, byte write strobes
//   i_mN_rstrb              master N read strobe (request = rstrb | any wstrb, level-sensitive)
//   o_mN_rdata              master N read data, valid with o_mN_done, held until its next read
//   o_mN_done               master N one-cycle completion pulse
//   o_s_addr/o_s_wdata      registered slave address / write data, held while idle
//   o_s_wstrb/o_s_rstrb     slave strobes, high only in the issue cycle
//   i_s_rdata               slave read data, valid RD_LAT cycles after o_s_rstrb
//   o_owner                 current/last granted master (0 = m0, 1 = m1)
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter bit          PRIO_FIX = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_m0_addr,
    input  logic [DATA_W-1:0]     i_m0_wdata,
    input  logic [DATA_W/8-1:0]   i_m0_wstrb,
    input  logic                  i_m0_rstrb,
    output logic [DATA_W-1:0]     o_m0_rdata,
    output logic                  o_m0_done,
    input  logic [ADDR_W-1:0]     i_m1_addr,
    input  logic [DATA_W-1:0]     i_m1_wdata,
    input  logic [DATA_W/8-1:0]   i_m1_wstrb,
    input  logic                  i_m1_rstrb,
    output logic [DATA_W-1:0]     o_m1_rdata,
    output logic                  o_m1_done,
    output logic [ADDR_W-1:0]     o_s_addr,
    output logic [DATA_W-1:0]     o_s_wdata,
    output logic [DATA_W/8-1:0]   o_s_wstrb,
    output logic                  o_s_rstrb,
    input  logic [DATA_W-1:0]     i_s_rdata,
    output logic                  o_owner
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              r_state;
    logic                r_last;      // last-served master, also drives o_owner
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic [STRB_W-1:0]   r_s_wstrb;
    logic                r_s_rstrb;
    logic [STRB_W-1:0]   r_wstrb_lat; // latched strobe copies of the granted request
    logic                r_rstrb_lat;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_m0_done;
    logic                r_m1_done;

    logic                w_m0_req;
    logic                w_m1_req;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_rstrb;

    always_comb begin
        w_m0_req = i_m0_rstrb | (|i_m0_wstrb);
        w_m1_req = i_m1_rstrb | (|i_m1_wstrb);
        // Tie: fixed priority to m0, or the master not served last.
        if (w_m0_req && w_m1_req) begin
            w_grant = PRIO_FIX ? 1'b0 : ~r_last;
        end else begin
            w_grant = w_m1_req;
        end
        w_addr  = w_grant ? i_m1_addr  : i_m0_addr;
        w_wdata = w_grant ? i_m1_wdata : i_m0_wdata;
        w_wstrb = w_grant ? i_m1_wstrb : i_m0_wstrb;
        w_rstrb = w_grant ? i_m1_rstrb : i_m0_rstrb;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_last      <= 1'b1;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_s_rstrb   <= 1'b0;
            r_wstrb_lat <= '0;
            r_rstrb_lat <= 1'b0;
            r_cnt       <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_done   <= 1'b0;
            r_m1_done   <= 1'b0;
        end else begin
            // Strobes and done pulses are single-cycle unless set below.
            r_s_wstrb <= '0;
            r_s_rstrb <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_m0_req || w_m1_req) begin
                        r_last      <= w_grant;
                        r_s_addr    <= w_addr;
                        r_s_wdata   <= w_wdata;
                        r_wstrb_lat <= w_wstrb;
                        r_rstrb_lat <= w_rstrb;
                        // Registered strobes are therefore high exactly in the issue cycle.
                        r_s_wstrb   <= w_wstrb;
                        r_s_rstrb   <= w_rstrb;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (r_rstrb_lat) begin
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                        r_state <= StWait;
                    end else begin
                        r_m0_done <= ~r_last;
                        r_m1_done <= r_last;
                        r_state   <= StDone;
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        if (r_last) begin
                            r_m1_rdata <= i_s_rdata;
                        end else begin
                            r_m0_rdata <= i_s_rdata;
                        end
                        r_m0_done <= ~r_last;
                        r_m1_done <= r_last;
                        r_state   <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    r_wstrb_lat <= '0;
                    r_rstrb_lat <= 1'b0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_m0_rdata = r_m0_rdata;
    assign o_m1_rdata = r_m1_rdata;
    assign o_m0_done  = r_m0_done;
    assign o_m1_done  = r_m1_done;
    assign o_s_addr   = r_s_addr;
    assign o_s_wdata  = r_s_wdata;
    assign o_s_wstrb  = r_s_wstrb;
    assign o_s_rstrb  = r_s_rstrb;
    assign o_owner    = r_last;

endmodule
